// File: rtl/regfile_write_arbiter.sv
// Register file write-port arbiter.
// A (ALU writeback) wins by default. B (memory writeback) is forced to win
// after losing MAX_WAIT consecutive edges. The write port outputs are registered.
module regfile_write_arbiter #(
    parameter int MAX_WAIT      = 4,   // legal 1..15
    parameter bit ZERO_SUPPRESS = 1'b1
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        ReqA,
    input  logic [4:0]  AddrA,
    input  logic [31:0] DataA,
    output logic        AckA,
    input  logic        ReqB,
    input  logic [4:0]  AddrB,
    input  logic [31:0] DataB,
    output logic        AckB,
    output logic        RegWrite,
    output logic [4:0]  WriteRegister,
    output logic [31:0] WriteData,
    output logic        Starved
);

    typedef enum logic {PRIO_A = 1'b0, FORCE_B = 1'b1} arbState_t;

    localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

    arbState_t   state, stateNext;
    logic [3:0]  waitCnt, waitCntNext;
    logic        xferA, xferB, xfer, writeEn;
    logic [4:0]  selAddr;
    logic [31:0] selData;

    // Arbiter state and starvation counter.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state   <= PRIO_A;
            waitCnt <= 4'd0;
        end else begin
            state   <= stateNext;
            waitCnt <= waitCntNext;
        end
    end

    // Grants, counter update and next state. Grants are held low during reset
    // so an in-flight request is not consumed; it gets granted after release.
    always_comb begin
        AckA        = 1'b0;
        AckB        = 1'b0;
        stateNext   = state;
        waitCntNext = 4'd0;
        case (state)
            PRIO_A: begin
                AckA = ReqA;
                AckB = ReqB & ~ReqA;
            end
            FORCE_B: begin
                AckB = ReqB;
                AckA = ReqA & ~ReqB;
            end
            default: ;
        endcase
        if (!Reset_n) begin
            AckA = 1'b0;
            AckB = 1'b0;
        end
        // Count consecutive lost edges; any win or idle B restarts the count.
        if (ReqB && !AckB)
            waitCntNext = waitCnt + 4'd1;
        case (state)
            PRIO_A:  if (ReqB && !AckB && waitCnt == WAIT_LAST) stateNext = FORCE_B;
            FORCE_B: if (AckB || !ReqB) stateNext = PRIO_A;
            default: stateNext = PRIO_A;
        endcase
    end

    assign Starved = (state == FORCE_B);

    // Select the winning requester's payload; $0 writes are acked but dropped.
    always_comb begin
        xferA   = ReqA & AckA;
        xferB   = ReqB & AckB;
        xfer    = xferA | xferB;
        selAddr = xferB ? AddrB : AddrA;
        selData = xferB ? DataB : DataA;
        writeEn = xfer & ~(ZERO_SUPPRESS && selAddr == 5'd0);
    end

    // Registered write port; address/data hold when nothing is written.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            RegWrite      <= 1'b0;
            WriteRegister <= 5'd0;
            WriteData     <= 32'd0;
        end else begin
            RegWrite <= writeEn;
            if (writeEn) begin
                WriteRegister <= selAddr;
                WriteData     <= selData;
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter (MAX_WAIT=4, ZERO_SUPPRESS=1).
// Each step states the grants it requires; the resulting write-port contents
// are queued and compared against the DUT one edge later.
module tb_regfile_write_arbiter;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        ReqA = 1'b0, ReqB = 1'b0;
    logic [4:0]  AddrA = '0, AddrB = '0;
    logic [31:0] DataA = '0, DataB = '0;
    logic        AckA, AckB, RegWrite, Starved;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;

    typedef struct {
        logic        rw;
        logic [4:0]  addr;
        logic [31:0] data;
    } wrExp_t;

    wrExp_t      sb[$];
    int          nChecks = 0;
    int          nFails  = 0;
    logic [4:0]  holdAddr = '0;
    logic [31:0] holdData = '0;

    regfile_write_arbiter #(.MAX_WAIT(4), .ZERO_SUPPRESS(1'b1)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .ReqA(ReqA), .AddrA(AddrA), .DataA(DataA), .AckA(AckA),
        .ReqB(ReqB), .AddrB(AddrB), .DataB(DataB), .AckB(AckB),
        .RegWrite(RegWrite), .WriteRegister(WriteRegister),
        .WriteData(WriteData), .Starved(Starved)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Compare the write port against the entry queued at the previous edge.
    task automatic popCheck(input string tag);
        wrExp_t e;
        if (sb.size() == 0) begin
            chk({tag, " sb empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk({tag, " RegWrite"}, {31'd0, RegWrite}, {31'd0, e.rw});
        chk({tag, " WriteRegister"}, {27'd0, WriteRegister}, {27'd0, e.addr});
        chk({tag, " WriteData"}, WriteData, e.data);
    endtask

    // One clock: drive, check grants mid-cycle, queue expected write port.
    task automatic step(input string tag,
                        input logic ra, input logic [4:0] aa, input logic [31:0] da,
                        input logic rb, input logic [4:0] ab, input logic [31:0] db,
                        input logic expA, input logic expB, input logic expSt);
        wrExp_t e;
        ReqA = ra; AddrA = aa; DataA = da;
        ReqB = rb; AddrB = ab; DataB = db;
        @(negedge Clk);
        popCheck(tag);
        chk({tag, " AckA"}, {31'd0, AckA}, {31'd0, expA});
        chk({tag, " AckB"}, {31'd0, AckB}, {31'd0, expB});
        chk({tag, " Starved"}, {31'd0, Starved}, {31'd0, expSt});
        e.rw = 1'b0;
        if (expA && ra && aa != 5'd0) begin
            e.rw = 1'b1; holdAddr = aa; holdData = da;
        end else if (expB && rb && ab != 5'd0) begin
            e.rw = 1'b1; holdAddr = ab; holdData = db;
        end
        e.addr = holdAddr;
        e.data = holdData;
        sb.push_back(e);
        @(posedge Clk);
        #1;
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Reset for one edge with requests left as they are; grants must stay low.
    task automatic resetStep(input string tag);
        wrExp_t e;
        Reset_n = 1'b0;
        @(negedge Clk);
        if (sb.size() != 0) popCheck(tag);
        chk({tag, " AckA"}, {31'd0, AckA}, 32'd0);
        chk({tag, " AckB"}, {31'd0, AckB}, 32'd0);
        holdAddr = '0;
        holdData = '0;
        e.rw = 1'b0; e.addr = '0; e.data = '0;
        sb.push_back(e);
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
    endtask

    initial begin
        resetStep("rst");

        // Single A write, visible one cycle later, then RegWrite drops.
        step("singleA", 1, 5'b11010, 32'h8000007F, 0, 0, 0, 1, 0, 0);
        idle("singleA+1");
        idle("singleA+2");

        // Simultaneous: A first, then B on the next edge.
        step("simA", 1, 5'd3, 32'h1, 1, 5'd19, 32'hD83F003F, 1, 0, 0);
        step("simB", 0, 5'd0, 32'h0, 1, 5'd19, 32'hD83F003F, 0, 1, 0);
        idle("sim+1");
        idle("sim+2");

        // Starvation: B loses 4 edges, then is forced through for one cycle.
        for (int i = 0; i < 4; i++)
            step($sformatf("starveLose%0d", i), 1, 5'(i + 1), 32'hA000_0000 + i,
                 1, 5'd7, 32'hBEEF_0007, 1, 0, 0);
        step("starveForce", 1, 5'd5, 32'hA000_0004, 1, 5'd7, 32'hBEEF_0007, 0, 1, 1);
        step("starveAfter", 1, 5'd5, 32'hA000_0004, 0, 5'd0, 32'h0, 1, 0, 0);
        idle("starve+1");

        // Write to $0: acked, no RegWrite, address/data hold.
        step("zero", 1, 5'd0, 32'hFFFFFFFF, 0, 0, 0, 1, 0, 0);
        idle("zero+1");
        idle("zero+2");

        // Reset with B having lost two edges; counter must restart from 0.
        step("preRst0", 1, 5'd9, 32'h0000_0009, 1, 5'd12, 32'h0C0C_0C0C, 1, 0, 0);
        step("preRst1", 1, 5'd10, 32'h0000_000A, 1, 5'd12, 32'h0C0C_0C0C, 1, 0, 0);
        resetStep("midRst");
        for (int i = 0; i < 4; i++)
            step($sformatf("postRstLose%0d", i), 1, 5'(i + 20), 32'h5000_0000 + i,
                 1, 5'd12, 32'h0C0C_0C0C, 1, 0, 0);
        step("postRstForce", 1, 5'd24, 32'h5000_0004, 1, 5'd12, 32'h0C0C_0C0C, 0, 1, 1);
        idle("postRst+1");
        idle("postRst+2");

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

endmodule
